pe_frame_loader: RTL and testbench
==================================

Name: pe_frame_loader

Overview:
- Upstream feeder for the pixel processing element (pe).
- Accepts a serial RGB pixel stream using a valid/ready handshake and packs NUM_PIXELS pixels into the flat 8-bit-per-pixel buses that pe consumes.
- Accumulates per-channel sums and produces the per-channel mean (the pe expected-colour inputs), then launches pe background removal.
- Runs the done/acknowledge handshake with pe before accepting the next frame.

Parameters:
- NUM_PIXELS, 4, pixels per frame; power of two, at least 2.
- LOG2_PIX, 2, log2(NUM_PIXELS); used for the shift-divide and to size the counter and sums.

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- In_Valid  in  1  upstream pixel valid.
- In_Ready  out  1  loader can accept a pixel.
- In_R, In_G, In_B  in  8 each  incoming pixel channels.
- In_Last  in  1  marks the final pixel of a frame.
- Red_Pix, Green_Pix, Blue_Pix  out  8*NUM_PIXELS each  packed frame to pe; pixel i occupies bits [8i+7:8i].
- Red_Exp, Green_Exp, Blue_Exp  out  8 each  per-channel frame mean.
- Start_Bg  out  1  one-cycle start pulse to pe.
- Pe_Done  in  1  pe background-removal done (pe Qbgd).
- Ack  out  1  acknowledge to pe.
- Frame_Err  out  1  sticky framing-error flag.
- Frame_Count  out  16  count of completed frames.

Behaviour:
- **Reset** (Reset==0 at a rising edge): state=FILL, pixel index=0, sums=0.
  - All outputs 0, except In_Ready=1 one cycle after reset releases.
  - Reset has priority in every state, including mid-frame and while waiting on pe. A partial frame is discarded.
- **States:** FILL, ISSUE, WAIT, ACK.
- **FILL:**
  - In_Ready=1.
  - Each accepted beat (In_Valid & In_Ready) writes In_R/G/B into slot idx of the three packed buses.
  - The same beat adds each channel into its sum. Sums are 8+LOG2_PIX bits wide and cannot overflow.
  - idx increments on every accepted beat.
  - Beat at idx==NUM_PIXELS-1 with In_Last=1: go to ISSUE.
  - Beat with In_Last mismatched to idx (early Last, or missing Last on the final slot):
    - Frame_Err<=1 (sticky until reset).
    - idx and sums clear; frame is dropped and no Start_Bg is issued.
    - The packed buses keep the partially written data.
  - No beat is accepted when In_Valid=0.
- **ISSUE** (exactly 1 cycle):
  - In_Ready=0, Start_Bg=1.
  - Red_Exp = red_sum >> LOG2_PIX (truncating divide), likewise for G and B.
  - Exp outputs are registered and become valid in the same cycle Start_Bg is high.
  - Next state: WAIT.
- **WAIT:**
  - In_Ready=0, Start_Bg=0.
  - Packed buses and Exp outputs are held stable.
  - Pe_Done=1 sampled: go to ACK.
- **ACK:**
  - Ack=1 and held while Pe_Done=1.
  - On the first cycle Pe_Done=0 is sampled: Ack<=0, Frame_Count++ (wraps at 65535->0), idx and sums clear, go to FILL.
  - In_Ready returns to 1 on the same edge.
- **Latency:** the last accepted beat is followed by Start_Bg on the next cycle. The earliest next accepted pixel is 1 cycle after Pe_Done falls.
- **Pe_Done already 1 when WAIT is entered:** go to ACK on the first WAIT cycle; no extra stall.
- **Pe_Done pulse in ISSUE:** ignored; only WAIT samples it.
- **Hold-over:** packed buses and Exp outputs keep the last frame's values until overwritten by the next frame's beats or ISSUE.

Test Plan:
- **Reset then normal frame:** beats (204,0,0), (61,133,198) x3, Last on the 4th beat.
  - Red_Pix=32'h3D3D3DCC, Green_Pix=32'h858585_00, Blue_Pix=32'hC6C6C6_00.
  - Red_Exp=96, Green_Exp=99, Blue_Exp=148.
  - Start_Bg high exactly 1 cycle, on the cycle after the 4th beat.
- **Done handshake:** Pe_Done raised 10 cycles after Start_Bg, held 3 cycles -> Ack high while Pe_Done is high, drops 1 cycle after Pe_Done falls, Frame_Count=1, In_Ready=1.
- **Backpressure and gaps:** In_Valid toggles 1,0,1,0 between beats; In_Valid=1 during WAIT.
  - No beats are lost or duplicated and none are accepted in WAIT.
  - Frame data matches the first test.
- **Framing error:** In_Last on the 2nd beat -> Frame_Err=1, no Start_Bg. The next clean 4-beat frame still completes with correct means, and Frame_Err stays 1.
- **Saturation corner:** four beats (255,255,255) -> sums 1020, Exp=255 on all channels, no overflow.
- **Reset mid-operation:** Reset=0 for 1 cycle after 2 beats, and separately during WAIT.
  - All outputs return to 0 and state returns to FILL.
  - Frame_Count is unchanged-from-reset, i.e. 0.

Source files
------------

// File: rtl/pe_frame_loader.sv
// Packs a valid/ready RGB pixel stream into flat frame buses for pe.
// Computes per-channel means, launches background removal and runs the done/ack handshake.
module pe_frame_loader #(
    parameter int NUM_PIXELS = 4,
    parameter int LOG2_PIX   = 2
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    input  logic [7:0]              In_R,
    input  logic [7:0]              In_G,
    input  logic [7:0]              In_B,
    input  logic                    In_Last,
    output logic [8*NUM_PIXELS-1:0] Red_Pix,
    output logic [8*NUM_PIXELS-1:0] Green_Pix,
    output logic [8*NUM_PIXELS-1:0] Blue_Pix,
    output logic [7:0]              Red_Exp,
    output logic [7:0]              Green_Exp,
    output logic [7:0]              Blue_Exp,
    output logic                    Start_Bg,
    input  logic                    Pe_Done,
    output logic                    Ack,
    output logic                    Frame_Err,
    output logic [15:0]             Frame_Count
);

    localparam int SUM_W = 8 + LOG2_PIX;

    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    logic [1:0]              r_state;
    logic [LOG2_PIX-1:0]     r_idx;
    logic [SUM_W-1:0]        r_sumR;
    logic [SUM_W-1:0]        r_sumG;
    logic [SUM_W-1:0]        r_sumB;
    logic [8*NUM_PIXELS-1:0] r_redPix;
    logic [8*NUM_PIXELS-1:0] r_greenPix;
    logic [8*NUM_PIXELS-1:0] r_bluePix;
    logic [7:0]              r_redExp;
    logic [7:0]              r_greenExp;
    logic [7:0]              r_blueExp;
    logic                    r_inReady;
    logic                    r_startBg;
    logic                    r_ack;
    logic                    r_frameErr;
    logic [15:0]             r_frameCount;

    logic                    w_accept;
    logic                    w_lastSlot;
    logic [LOG2_PIX+2:0]     w_bitBase;
    logic [SUM_W-1:0]        w_sumRNext;
    logic [SUM_W-1:0]        w_sumGNext;
    logic [SUM_W-1:0]        w_sumBNext;

    assign w_accept   = In_Valid & r_inReady;
    assign w_lastSlot = (r_idx == LOG2_PIX'(NUM_PIXELS - 1));
    assign w_bitBase  = {r_idx, 3'b000};
    assign w_sumRNext = r_sumR + SUM_W'(In_R);
    assign w_sumGNext = r_sumG + SUM_W'(In_G);
    assign w_sumBNext = r_sumB + SUM_W'(In_B);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state      <= FILL;
            r_idx        <= '0;
            r_sumR       <= '0;
            r_sumG       <= '0;
            r_sumB       <= '0;
            r_redPix     <= '0;
            r_greenPix   <= '0;
            r_bluePix    <= '0;
            r_redExp     <= '0;
            r_greenExp   <= '0;
            r_blueExp    <= '0;
            r_inReady    <= 1'b0;
            r_startBg    <= 1'b0;
            r_ack        <= 1'b0;
            r_frameErr   <= 1'b0;
            r_frameCount <= '0;
        end else begin
            r_startBg <= 1'b0;
            case (r_state)
                FILL: begin
                    r_inReady <= 1'b1;
                    if (w_accept) begin
                        r_redPix[w_bitBase +: 8]   <= In_R;
                        r_greenPix[w_bitBase +: 8] <= In_G;
                        r_bluePix[w_bitBase +: 8]  <= In_B;
                        // A Last flag out of step with the slot index drops the frame.
                        if (In_Last != w_lastSlot) begin
                            r_frameErr <= 1'b1;
                            r_idx      <= '0;
                            r_sumR     <= '0;
                            r_sumG     <= '0;
                            r_sumB     <= '0;
                        end else if (w_lastSlot) begin
                            r_state    <= ISSUE;
                            r_inReady  <= 1'b0;
                            r_startBg  <= 1'b1;
                            r_redExp   <= w_sumRNext[LOG2_PIX +: 8];
                            r_greenExp <= w_sumGNext[LOG2_PIX +: 8];
                            r_blueExp  <= w_sumBNext[LOG2_PIX +: 8];
                        end else begin
                            r_idx  <= r_idx + 1'b1;
                            r_sumR <= w_sumRNext;
                            r_sumG <= w_sumGNext;
                            r_sumB <= w_sumBNext;
                        end
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (Pe_Done) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                    end
                end
                ACK: begin
                    if (!Pe_Done) begin
                        r_ack        <= 1'b0;
                        r_frameCount <= r_frameCount + 16'd1;
                        r_idx        <= '0;
                        r_sumR       <= '0;
                        r_sumG       <= '0;
                        r_sumB       <= '0;
                        r_state      <= FILL;
                        r_inReady    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    assign In_Ready    = r_inReady;
    assign Red_Pix     = r_redPix;
    assign Green_Pix   = r_greenPix;
    assign Blue_Pix    = r_bluePix;
    assign Red_Exp     = r_redExp;
    assign Green_Exp   = r_greenExp;
    assign Blue_Exp    = r_blueExp;
    assign Start_Bg    = r_startBg;
    assign Ack         = r_ack;
    assign Frame_Err   = r_frameErr;
    assign Frame_Count = r_frameCount;

endmodule

// File: tb/tb_pe_frame_loader.sv
// Directed bench for pe_frame_loader: hand-computed frames, handshake, framing error,
// saturation and mid-operation reset.
module tb_pe_frame_loader;

    logic        Clk;
    logic        Reset;
    logic        In_Valid;
    logic        In_Ready;
    logic [7:0]  In_R;
    logic [7:0]  In_G;
    logic [7:0]  In_B;
    logic        In_Last;
    logic [31:0] Red_Pix;
    logic [31:0] Green_Pix;
    logic [31:0] Blue_Pix;
    logic [7:0]  Red_Exp;
    logic [7:0]  Green_Exp;
    logic [7:0]  Blue_Exp;
    logic        Start_Bg;
    logic        Pe_Done;
    logic        Ack;
    logic        Frame_Err;
    logic [15:0] Frame_Count;

    int checks;
    int errors;
    int startCount;

    pe_frame_loader #(.NUM_PIXELS(4), .LOG2_PIX(2)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .In_Valid(In_Valid),
        .In_Ready(In_Ready),
        .In_R(In_R),
        .In_G(In_G),
        .In_B(In_B),
        .In_Last(In_Last),
        .Red_Pix(Red_Pix),
        .Green_Pix(Green_Pix),
        .Blue_Pix(Blue_Pix),
        .Red_Exp(Red_Exp),
        .Green_Exp(Green_Exp),
        .Blue_Exp(Blue_Exp),
        .Start_Bg(Start_Bg),
        .Pe_Done(Pe_Done),
        .Ack(Ack),
        .Frame_Err(Frame_Err),
        .Frame_Count(Frame_Count)
    );

    // 10-unit clock period
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Start_Bg is counted once per cycle it is high, so a stretched pulse shows up
    always @(negedge Clk) begin
        if (Start_Bg === 1'b1) startCount++;
    end

    // Guard against a hung handshake
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Presents one beat and holds it until the loader takes it
    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] g,
                                 input logic [7:0] b, input logic last);
        logic wasReady;
        logic accepted;
        In_R     = r;
        In_G     = g;
        In_B     = b;
        In_Last  = last;
        In_Valid = 1'b1;
        accepted = 1'b0;
        for (int n = 0; n < 50 && !accepted; n++) begin
            wasReady = In_Ready;
            step();
            if (wasReady) accepted = 1'b1;
        end
        In_Valid = 1'b0;
        In_Last  = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_timeout: beat not accepted within 50 cycles");
        end
    endtask

    task automatic sendFrameOne(input bit gaps);
        applyStimulus(8'd204, 8'd0, 8'd0, 1'b0);
        if (gaps) step();
        applyStimulus(8'd61, 8'd133, 8'd198, 1'b0);
        if (gaps) step();
        applyStimulus(8'd61, 8'd133, 8'd198, 1'b0);
        if (gaps) step();
        applyStimulus(8'd61, 8'd133, 8'd198, 1'b1);
    endtask

    task automatic doneHandshake();
        Pe_Done = 1'b1;
        step();
        checkOutput("ack_raised", {31'd0, Ack}, 32'd1);
        Pe_Done = 1'b0;
        step();
        checkOutput("ack_dropped", {31'd0, Ack}, 32'd0);
        checkOutput("ready_after_ack", {31'd0, In_Ready}, 32'd1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        startCount = 0;
        Reset      = 1'b0;
        In_Valid   = 1'b0;
        In_R       = 8'd0;
        In_G       = 8'd0;
        In_B       = 8'd0;
        In_Last    = 1'b0;
        Pe_Done    = 1'b0;

        // Reset state
        step();
        step();
        checkOutput("rst_ready", {31'd0, In_Ready}, 32'd0);
        checkOutput("rst_start", {31'd0, Start_Bg}, 32'd0);
        checkOutput("rst_ack", {31'd0, Ack}, 32'd0);
        checkOutput("rst_err", {31'd0, Frame_Err}, 32'd0);
        checkOutput("rst_count", {16'd0, Frame_Count}, 32'd0);
        checkOutput("rst_redpix", Red_Pix, 32'd0);
        checkOutput("rst_redexp", {24'd0, Red_Exp}, 32'd0);
        Reset = 1'b1;
        step();
        checkOutput("ready_after_rst", {31'd0, In_Ready}, 32'd1);

        // Normal frame
        sendFrameOne(1'b0);
        checkOutput("f1_start", {31'd0, Start_Bg}, 32'd1);
        checkOutput("f1_ready_issue", {31'd0, In_Ready}, 32'd0);
        checkOutput("f1_redpix", Red_Pix, 32'h3D3D3DCC);
        checkOutput("f1_greenpix", Green_Pix, 32'h85858500);
        checkOutput("f1_bluepix", Blue_Pix, 32'hC6C6C600);
        checkOutput("f1_redexp", {24'd0, Red_Exp}, 32'd96);
        checkOutput("f1_greenexp", {24'd0, Green_Exp}, 32'd99);
        checkOutput("f1_blueexp", {24'd0, Blue_Exp}, 32'd148);
        step();
        checkOutput("f1_start_low", {31'd0, Start_Bg}, 32'd0);
        checkOutput("f1_start_pulses", startCount, 32'd1);

        // Done handshake: Pe_Done held for three cycles
        repeat (8) step();
        checkOutput("f1_ack_idle", {31'd0, Ack}, 32'd0);
        Pe_Done = 1'b1;
        step();
        checkOutput("hs_ack_1", {31'd0, Ack}, 32'd1);
        checkOutput("hs_ready_low", {31'd0, In_Ready}, 32'd0);
        step();
        step();
        checkOutput("hs_ack_3", {31'd0, Ack}, 32'd1);
        checkOutput("hs_count_hold", {16'd0, Frame_Count}, 32'd0);
        Pe_Done = 1'b0;
        step();
        checkOutput("hs_ack_drop", {31'd0, Ack}, 32'd0);
        checkOutput("hs_count", {16'd0, Frame_Count}, 32'd1);
        checkOutput("hs_ready", {31'd0, In_Ready}, 32'd1);

        // Backpressure gaps, then valid held high while waiting on pe
        sendFrameOne(1'b1);
        In_R     = 8'hEE;
        In_G     = 8'hEE;
        In_B     = 8'hEE;
        In_Valid = 1'b1;
        repeat (4) step();
        checkOutput("bp_ready_wait", {31'd0, In_Ready}, 32'd0);
        checkOutput("bp_redpix", Red_Pix, 32'h3D3D3DCC);
        checkOutput("bp_greenpix", Green_Pix, 32'h85858500);
        checkOutput("bp_bluepix", Blue_Pix, 32'hC6C6C600);
        checkOutput("bp_redexp", {24'd0, Red_Exp}, 32'd96);
        checkOutput("bp_blueexp", {24'd0, Blue_Exp}, 32'd148);
        In_Valid = 1'b0;
        doneHandshake();
        checkOutput("bp_count", {16'd0, Frame_Count}, 32'd2);
        checkOutput("bp_start_pulses", startCount, 32'd2);

        // Early Last on the second beat drops the frame
        applyStimulus(8'd10, 8'd20, 8'd30, 1'b0);
        applyStimulus(8'd40, 8'd50, 8'd60, 1'b1);
        checkOutput("fe_err", {31'd0, Frame_Err}, 32'd1);
        checkOutput("fe_start", {31'd0, Start_Bg}, 32'd0);
        checkOutput("fe_ready", {31'd0, In_Ready}, 32'd1);
        checkOutput("fe_partial_redpix", Red_Pix, 32'h3D3D280A);
        repeat (3) step();
        checkOutput("fe_no_start", startCount, 32'd2);
        applyStimulus(8'd8, 8'd16, 8'd24, 1'b0);
        applyStimulus(8'd8, 8'd16, 8'd24, 1'b0);
        applyStimulus(8'd12, 8'd20, 8'd28, 1'b0);
        applyStimulus(8'd12, 8'd20, 8'd28, 1'b1);
        checkOutput("fe2_start", {31'd0, Start_Bg}, 32'd1);
        checkOutput("fe2_redpix", Red_Pix, 32'h0C0C0808);
        checkOutput("fe2_redexp", {24'd0, Red_Exp}, 32'd10);
        checkOutput("fe2_greenexp", {24'd0, Green_Exp}, 32'd18);
        checkOutput("fe2_blueexp", {24'd0, Blue_Exp}, 32'd26);
        checkOutput("fe2_err_sticky", {31'd0, Frame_Err}, 32'd1);
        step();
        doneHandshake();
        checkOutput("fe2_count", {16'd0, Frame_Count}, 32'd3);

        // Saturation corner: full-scale pixels must not overflow the sums
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'd255, 8'd255, 8'd255, (i == 3));
        end
        checkOutput("sat_redexp", {24'd0, Red_Exp}, 32'd255);
        checkOutput("sat_greenexp", {24'd0, Green_Exp}, 32'd255);
        checkOutput("sat_blueexp", {24'd0, Blue_Exp}, 32'd255);
        checkOutput("sat_bluepix", Blue_Pix, 32'hFFFFFFFF);
        step();
        doneHandshake();
        checkOutput("sat_count", {16'd0, Frame_Count}, 32'd4);

        // Reset after two beats discards the partial frame
        applyStimulus(8'd1, 8'd2, 8'd3, 1'b0);
        applyStimulus(8'd1, 8'd2, 8'd3, 1'b0);
        Reset = 1'b0;
        step();
        checkOutput("mr_ready", {31'd0, In_Ready}, 32'd0);
        checkOutput("mr_count", {16'd0, Frame_Count}, 32'd0);
        checkOutput("mr_err", {31'd0, Frame_Err}, 32'd0);
        checkOutput("mr_redpix", Red_Pix, 32'd0);
        checkOutput("mr_redexp", {24'd0, Red_Exp}, 32'd0);
        Reset = 1'b1;
        step();
        checkOutput("mr_ready_back", {31'd0, In_Ready}, 32'd1);
        sendFrameOne(1'b0);
        checkOutput("mr_f_start", {31'd0, Start_Bg}, 32'd1);
        checkOutput("mr_f_redexp", {24'd0, Red_Exp}, 32'd96);
        checkOutput("mr_f_greenexp", {24'd0, Green_Exp}, 32'd99);
        checkOutput("mr_f_blueexp", {24'd0, Blue_Exp}, 32'd148);

        // Reset while waiting on pe
        step();
        step();
        Reset = 1'b0;
        step();
        checkOutput("wr_redpix", Red_Pix, 32'd0);
        checkOutput("wr_greenexp", {24'd0, Green_Exp}, 32'd0);
        checkOutput("wr_start", {31'd0, Start_Bg}, 32'd0);
        checkOutput("wr_ack", {31'd0, Ack}, 32'd0);
        checkOutput("wr_count", {16'd0, Frame_Count}, 32'd0);
        Reset = 1'b1;
        step();
        checkOutput("wr_ready_back", {31'd0, In_Ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
